// File: rtl/lsu_pkg.sv
// Shared LSU types and default sizing for the load forward searcher.
//   state_e          : searcher FSM states
//   *_DEF            : default data width and queue sizes
//   *_IDX_W_DEF      : index widths for the default queue sizes
package lsu_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned LDQ_SIZE_DEF  = 32;
  localparam int unsigned STQ_SIZE_DEF  = 32;
  localparam int unsigned LDQ_IDX_W_DEF = $clog2(LDQ_SIZE_DEF);
  localparam int unsigned STQ_IDX_W_DEF = $clog2(STQ_SIZE_DEF);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEARCH    = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_MEM_REQ   = 3'd3,
    S_MEM_RESP  = 3'd4,
    S_DRAIN     = 3'd5,
    S_RESPOND   = 3'd6
  } state_e;

endpackage

// File: rtl/load_forward_searcher_if.sv
// Bundle of the searcher's load request, STQ snapshot, memory and writeback signals.
//   slave  : searcher side (consumes load/STQ/memory-response, drives request/result)
//   master : environment side (LSU pipeline, STQ and memory)
interface load_forward_searcher_if
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned LDQ_SIZE = LDQ_SIZE_DEF,
  parameter int unsigned STQ_SIZE = STQ_SIZE_DEF
);
  localparam int unsigned LDQ_IDX_W = $clog2(LDQ_SIZE);
  localparam int unsigned STQ_IDX_W = $clog2(STQ_SIZE);

  logic                     load_valid;
  logic                     load_ready;
  logic [LDQ_IDX_W-1:0]     load_ldq_index;
  logic [XLEN-1:0]          load_address;
  logic [STQ_SIZE-1:0]      load_store_mask;
  logic [STQ_SIZE-1:0]      stq_valid;
  logic [STQ_SIZE-1:0]      stq_address_valid;
  logic [STQ_SIZE*XLEN-1:0] stq_address;
  logic [STQ_SIZE-1:0]      stq_data_valid;
  logic [STQ_SIZE*XLEN-1:0] stq_data;
  logic [STQ_IDX_W-1:0]     stq_head;
  logic                     kill;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [XLEN-1:0]          mem_req_address;
  logic                     mem_resp_valid;
  logic [XLEN-1:0]          mem_resp_data;
  logic                     result_valid;
  logic [LDQ_IDX_W-1:0]     result_ldq_index;
  logic [XLEN-1:0]          result_data;
  logic                     result_forwarded;
  logic [STQ_IDX_W-1:0]     result_forward_stq_index;

  modport slave (
    input  load_valid, load_ldq_index, load_address, load_store_mask,
    input  stq_valid, stq_address_valid, stq_address, stq_data_valid, stq_data, stq_head,
    input  kill, mem_req_ready, mem_resp_valid, mem_resp_data,
    output load_ready, mem_req_valid, mem_req_address,
    output result_valid, result_ldq_index, result_data, result_forwarded, result_forward_stq_index
  );

  modport master (
    output load_valid, load_ldq_index, load_address, load_store_mask,
    output stq_valid, stq_address_valid, stq_address, stq_data_valid, stq_data, stq_head,
    output kill, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  load_ready, mem_req_valid, mem_req_address,
    input  result_valid, result_ldq_index, result_data, result_forwarded, result_forward_stq_index
  );

endinterface

// File: rtl/stq_forward_picker.sv
// Picks the youngest candidate store, age measured from the STQ head.
//   i_cand  : per-entry candidate flags (older, valid, resolved, same address)
//   i_head  : index of the oldest store
//   o_hit_c : at least one candidate
//   o_idx_c : index of the youngest candidate
module stq_forward_picker
  import lsu_pkg::*;
#(
  parameter int unsigned STQ_SIZE = STQ_SIZE_DEF
) (
  input  logic [STQ_SIZE-1:0]         i_cand,
  input  logic [$clog2(STQ_SIZE)-1:0] i_head,
  output logic                        o_hit_c,
  output logic [$clog2(STQ_SIZE)-1:0] o_idx_c
);
  localparam int unsigned IDX_W = $clog2(STQ_SIZE);

  logic [IDX_W-1:0] w_age;
  logic [IDX_W-1:0] w_best_age;

  // Age wraps naturally in IDX_W bits; larger age means younger store.
  always_comb begin
    o_hit_c    = 1'b0;
    o_idx_c    = '0;
    w_age      = '0;
    w_best_age = '0;
    for (int unsigned i = 0; i < STQ_SIZE; i++) begin
      w_age = IDX_W'(i) - i_head;
      if (i_cand[i] && (!o_hit_c || (w_age > w_best_age))) begin
        o_hit_c    = 1'b1;
        o_idx_c    = IDX_W'(i);
        w_best_age = w_age;
      end
    end
  end

endmodule

// File: rtl/load_forward_searcher.sv
// Load-side STQ searcher: forwards data from the youngest older matching store,
// waits for its data, or falls back to a memory read; writes back one result per load.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : load request, STQ snapshot, memory request/response, writeback
module load_forward_searcher
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned LDQ_SIZE = LDQ_SIZE_DEF,
  parameter int unsigned STQ_SIZE = STQ_SIZE_DEF
) (
  input logic                    clk,
  input logic                    reset_n,
  load_forward_searcher_if.slave bus
);
  localparam int unsigned LDQ_IDX_W = $clog2(LDQ_SIZE);
  localparam int unsigned STQ_IDX_W = $clog2(STQ_SIZE);

  state_e                 r_state, w_next;
  logic [LDQ_IDX_W-1:0]   r_ldq_idx, r_result_ldq_idx;
  logic [XLEN-1:0]        r_addr, r_result_data, w_res_data, w_pick_data, w_hold_data;
  logic [STQ_SIZE-1:0]    r_mask, w_cand;
  logic [STQ_IDX_W-1:0]   r_stq_idx, r_result_fwd_idx, w_res_idx, w_pick_idx;
  logic                   r_mem_req_valid, r_result_valid, r_result_fwd, w_res_fwd;
  logic                   w_hit, w_capture, w_clear_mask, w_set_idx, w_res_load;

  // Older, live, address-resolved stores to the same word.
  always_comb begin
    w_cand = '0;
    for (int unsigned i = 0; i < STQ_SIZE; i++) begin
      w_cand[i] = r_mask[i] & bus.stq_valid[i] & bus.stq_address_valid[i] &
                  (bus.stq_address[i*XLEN +: XLEN] == r_addr);
    end
  end

  stq_forward_picker #(.STQ_SIZE(STQ_SIZE)) u_picker (
    .i_cand  (w_cand),
    .i_head  (bus.stq_head),
    .o_hit_c (w_hit),
    .o_idx_c (w_pick_idx)
  );

  assign w_pick_data = bus.stq_data[32'(w_pick_idx)*XLEN +: XLEN];
  assign w_hold_data = bus.stq_data[32'(r_stq_idx)*XLEN +: XLEN];

  // Next state; kill is checked first in every busy state.
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_clear_mask = 1'b0;
    w_set_idx    = 1'b0;
    w_res_load   = 1'b0;
    w_res_data   = r_result_data;
    w_res_fwd    = r_result_fwd;
    w_res_idx    = r_result_fwd_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.load_valid && !bus.kill) begin
          w_capture = 1'b1;
          w_next    = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (bus.kill) begin
          w_next = S_IDLE;
        end else if (w_hit) begin
          w_set_idx = 1'b1;
          if (bus.stq_data_valid[w_pick_idx]) begin
            w_res_load = 1'b1;
            w_res_data = w_pick_data;
            w_res_fwd  = 1'b1;
            w_res_idx  = w_pick_idx;
            w_next     = S_RESPOND;
          end else begin
            w_next = S_WAIT_DATA;
          end
        end else begin
          w_next = S_MEM_REQ;
        end
      end
      S_WAIT_DATA: begin
        if (bus.kill) begin
          w_next = S_IDLE;
        end else if (bus.stq_data_valid[r_stq_idx]) begin
          w_res_load = 1'b1;
          w_res_data = w_hold_data;
          w_res_fwd  = 1'b1;
          w_res_idx  = r_stq_idx;
          w_next     = S_RESPOND;
        end else if (!bus.stq_valid[r_stq_idx]) begin
          // Store committed before its data showed up: drop it and look again.
          w_clear_mask = 1'b1;
          w_next       = S_SEARCH;
        end
      end
      S_MEM_REQ: begin
        if (bus.kill) begin
          w_next = bus.mem_req_ready ? S_DRAIN : S_IDLE;
        end else if (bus.mem_req_ready) begin
          w_next = S_MEM_RESP;
        end
      end
      S_MEM_RESP: begin
        if (bus.kill) begin
          // A response arriving alongside the kill is the one being discarded.
          w_next = bus.mem_resp_valid ? S_IDLE : S_DRAIN;
        end else if (bus.mem_resp_valid) begin
          w_res_load = 1'b1;
          w_res_data = bus.mem_resp_data;
          w_res_fwd  = 1'b0;
          w_res_idx  = '0;
          w_next     = S_RESPOND;
        end
      end
      S_DRAIN: begin
        // Still owed one response even if killed again.
        if (bus.mem_resp_valid) w_next = S_IDLE;
      end
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State, captured load and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_ldq_idx        <= '0;
      r_addr           <= '0;
      r_mask           <= '0;
      r_stq_idx        <= '0;
      r_mem_req_valid  <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_data    <= '0;
      r_result_fwd     <= 1'b0;
      r_result_fwd_idx <= '0;
      r_result_ldq_idx <= '0;
    end else begin
      r_state         <= w_next;
      r_mem_req_valid <= (w_next == S_MEM_REQ);
      r_result_valid  <= (w_next == S_RESPOND);
      if (w_capture) begin
        r_ldq_idx <= bus.load_ldq_index;
        r_addr    <= bus.load_address;
        r_mask    <= bus.load_store_mask;
      end
      if (w_clear_mask) r_mask[r_stq_idx] <= 1'b0;
      if (w_set_idx)    r_stq_idx <= w_pick_idx;
      if (w_res_load) begin
        r_result_data    <= w_res_data;
        r_result_fwd     <= w_res_fwd;
        r_result_fwd_idx <= w_res_idx;
        r_result_ldq_idx <= r_ldq_idx;
      end
    end
  end

  assign bus.load_ready               = (r_state == S_IDLE);
  assign bus.mem_req_valid            = r_mem_req_valid;
  assign bus.mem_req_address          = r_addr;
  assign bus.result_valid             = r_result_valid;
  assign bus.result_ldq_index         = r_result_ldq_idx;
  assign bus.result_data              = r_result_data;
  assign bus.result_forwarded         = r_result_fwd;
  assign bus.result_forward_stq_index = r_result_fwd_idx;

endmodule

// File: doc/load_forward_searcher.md
Name: load_forward_searcher

Overview:
- Load-side searcher of the LSU; the counterpart of the store-commit order-failure check.
- An executing load searches the STQ for the youngest older store with the same address.
  - Match with data ready: the data is forwarded.
  - Match without data: the load waits for the data.
  - No match: the load issues a memory read.
- Produces load writeback and the per-load metadata (forwarded flag, forwarding STQ index) that the commit-side failure check consumes.

Parameters:
XLEN, 32, data/address width
LDQ_SIZE, 32, load queue entries
STQ_SIZE, 32, store queue entries (power of two)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
load_valid  in  1  load request offered
load_ready  out  1  searcher idle, can accept
load_ldq_index  in  clog2(LDQ_SIZE)  LDQ slot of load
load_address  in  XLEN  load word address
load_store_mask  in  STQ_SIZE  1 = store older than this load
stq_valid  in  STQ_SIZE  entry occupied
stq_address_valid  in  STQ_SIZE  store address resolved
stq_address  in  STQ_SIZE*XLEN  store addresses
stq_data_valid  in  STQ_SIZE  store data present
stq_data  in  STQ_SIZE*XLEN  store data
stq_head  in  clog2(STQ_SIZE)  oldest store index
kill  in  1  flush in-flight load
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory accepts request
mem_req_address  out  XLEN  read address
mem_resp_valid  in  1  read data returned
mem_resp_data  in  XLEN  read data
result_valid  out  1  one-cycle writeback pulse
result_ldq_index  out  clog2(LDQ_SIZE)  load slot written back
result_data  out  XLEN  load value
result_forwarded  out  1  value came from STQ
result_forward_stq_index  out  clog2(STQ_SIZE)  source store when forwarded

Behaviour:
- Reset (reset_n low, async):
  - State IDLE; all registered outputs 0; captured load fields 0.
  - load_ready = (state==IDLE), so it reads 1 once reset releases.
- Accept: in IDLE, load_valid && load_ready captures index, address and mask; next state SEARCH.
- SEARCH (combinational over captured fields):
  - cand[i] = mask[i] & stq_valid[i] & stq_address_valid[i] & (stq_address[i]==addr).
  - Pick the youngest candidate: largest (i - stq_head) mod STQ_SIZE.
  - Unresolved older stores are ignored; the commit-side check catches the resulting ordering failures.
  - Hit with data valid: register data, forwarded=1, index; go to RESPOND.
  - Hit without data valid: hold index; go to WAIT_DATA.
  - No hit: go to MEM_REQ.
- WAIT_DATA:
  - If stq_data_valid[idx]: forward and go to RESPOND.
  - Else if stq_valid[idx]==0 (store committed): clear mask[idx] and return to SEARCH.
- MEM_REQ: mem_req_valid=1, address = captured addr, held until mem_req_ready; then MEM_RESP.
- MEM_RESP: on mem_resp_valid, register data, forwarded=0, forward index 0; go to RESPOND.
- RESPOND: result_valid=1 for exactly one cycle; then IDLE.
- Latency from the accept edge N:
  - Forward hit: result_valid during cycle N+2.
  - Miss: mem_req_valid from cycle N+2; result_valid one cycle after mem_resp_valid.
- kill:
  - Takes priority over every transition; result_valid is never asserted for a killed load.
  - From MEM_RESP: go to DRAIN, which discards exactly one mem_resp_valid and then enters IDLE.
  - From MEM_REQ with mem_req_ready high the same cycle: the request counts as accepted, so go to DRAIN.
  - From any other state: IDLE.
- Simultaneous events:
  - kill with load_valid in IDLE: not accepted.
  - Data valid and store commit in the same WAIT_DATA cycle: forward.
- Wrap-around: the age rank is subtraction mod STQ_SIZE in clog2(STQ_SIZE) bits.
- Empty mask or no valid stores: always MEM_REQ.

Decomposition:
- lsu_pkg holds:
  - state enum {IDLE, SEARCH, WAIT_DATA, MEM_REQ, MEM_RESP, DRAIN, RESPOND};
  - index-width localparams for LDQ and STQ.
- One sub-module, stq_forward_picker (combinational):
  - inputs: candidate vector and stq_head;
  - outputs: hit and the youngest older index.

Test Plan (STQ_SIZE=8):
- head=0; store 2 @0x100, data 0xAA valid; load addr 0x100, mask 0x0F → result_valid at N+2, data 0xAA, forwarded=1, index 2, no mem_req.
- head=6; stores 6 and 1 both @0x40 with data; mask covers 6,7,0,1 → forward from index 1 (youngest across wrap).
- Matching store 3 without data; data_valid rises 4 cycles later → state stays WAIT_DATA, then result forwarded from 3. Variant: store 3 commits instead → re-search → mem_req @addr.
- No match; mem_req_ready low 2 cycles, response data 0x1234 3 cycles later → mem_req held stable; result data 0x1234, forwarded=0.
- kill in MEM_RESP, then mem_resp_valid arrives → no result_valid, response swallowed, load_ready returns only after it.
- reset_n low mid-MEM_REQ → mem_req_valid and result_valid drop immediately (async), state IDLE.
